// File: rtl/kbd_calc_pkg.sv
// Shared definitions for the keyboard calculator: states, key classes,
// PS/2 scan codes, display nibble codes and the scan-code decoder.
package kbd_calc_pkg;

   typedef enum logic [2:0] {S_A, S_B, S_CALC, S_CONV, S_RES} state_e;

   typedef enum logic [2:0] {K_NONE, K_DIGIT, K_OP, K_ENTER, K_BKSP, K_ESC} key_kind_e;

   typedef struct packed {
      key_kind_e  kind;
      logic [3:0] val;
   } key_t;

   localparam logic [3:0] DIG_BLANK = 4'd15;
   localparam logic [3:0] OP_ADD    = 4'd10;
   localparam logic [3:0] OP_SUB    = 4'd11;
   localparam logic [3:0] OP_MUL    = 4'd12;

   localparam logic [8:0] SC_ENTER    = 9'h05A;
   localparam logic [8:0] SC_KP_ENTER = 9'h15A;
   localparam logic [8:0] SC_BKSP     = 9'h066;
   localparam logic [8:0] SC_ESC      = 9'h076;
   localparam logic [8:0] SC_KP_ADD   = 9'h079;
   localparam logic [8:0] SC_KP_SUB   = 9'h07B;
   localparam logic [8:0] SC_KP_MUL   = 9'h07C;
   localparam logic [8:0] SC_MINUS    = 9'h04E;

   localparam logic [8:0] SC_DIGIT [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                                            9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
   localparam logic [8:0] SC_KP_DIGIT [10] = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
                                               9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};

   // Operator keys carry their display nibble code in val.
   function automatic key_t decode_key(input logic [8:0] sc);
      key_t k;
      k.kind = K_NONE;
      k.val  = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         if (sc == SC_DIGIT[i] || sc == SC_KP_DIGIT[i]) begin
            k.kind = K_DIGIT;
            k.val  = 4'(i);
         end
      end
      case (sc)
         SC_KP_ADD:             begin k.kind = K_OP; k.val = OP_ADD; end
         SC_KP_SUB, SC_MINUS:   begin k.kind = K_OP; k.val = OP_SUB; end
         SC_KP_MUL:             begin k.kind = K_OP; k.val = OP_MUL; end
         SC_ENTER, SC_KP_ENTER: k.kind = K_ENTER;
         SC_BKSP:               k.kind = K_BKSP;
         SC_ESC:                k.kind = K_ESC;
         default: ;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/kbd_calc_core_bin2bcd.sv
// Sequential double-dabble converter: one bit per cycle, done pulse the
// cycle after the last shift.
module bin2bcd_seq #(
   parameter int RES_W      = 14,
   parameter int RES_DIGITS = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [RES_W-1:0]        bin_i,
   output logic                    done_o,
   output logic [4*RES_DIGITS-1:0] bcd_o
);

   localparam int CW = $clog2(RES_W + 1);
   localparam int NW = 4 * RES_DIGITS;

   logic [RES_W-1:0] bin_q, bin_d;
   logic [NW-1:0]    bcd_q, bcd_d, adj;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             active_q, active_d;
   logic             done_q, done_d;
   logic [NW+RES_W-1:0] sh;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      adj = bcd_q;
      for (int unsigned i = 0; i < RES_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      sh = {adj, bin_q} << 1;

      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      done_d   = 1'b0;
      if (start_i) begin
         bin_d    = bin_i;
         bcd_d    = '0;
         cnt_d    = CW'(RES_W);
         active_d = 1'b1;
      end else if (active_q) begin
         bcd_d = sh[NW+RES_W-1:RES_W];
         bin_d = sh[RES_W-1:0];
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end
      end
   end

   assign done_o = done_q;
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/kbd_calc_core.sv
// Keyboard calculator: operand entry FSM, ALU, sequential BCD conversion
// and 7-segment nibble display mux.
module kbd_calc_core
   import kbd_calc_pkg::*;
#(
   parameter int DIGITS     = 2,
   parameter int RES_DIGITS = 2 * DIGITS
) (
   input  logic                    clk_100Hz,
   input  logic                    rst_p,
   input  logic                    key_valid,
   input  logic                    key_make,
   input  logic [8:0]              scan_code,
   output logic [4*RES_DIGITS-1:0] disp_code,
   output logic                    disp_neg,
   output logic                    busy,
   output logic                    result_valid
);

   localparam int W     = $clog2(10 ** DIGITS);
   localparam int RES_W = 2 * W;
   localparam int DW    = 4 * DIGITS;
   localparam int NW    = 4 * RES_DIGITS;
   localparam logic [2:0] DIG_MAX = 3'(DIGITS);

   state_e        state_q, state_d;
   logic [DW-1:0] a_bcd_q, a_bcd_d, b_bcd_q, b_bcd_d;
   logic [2:0]    a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic [3:0]    op_q, op_d;
   logic          neg_q, neg_d;

   key_t             key;
   logic             key_acc;
   logic             do_clear;
   logic             conv_start, conv_done;
   logic [NW-1:0]    conv_bcd;
   logic [W-1:0]     a_bin, b_bin;
   logic [RES_W-1:0] alu_r;
   logic             alu_neg;
   logic [NW-1:0]    num;
   logic             seen;

   assign key     = decode_key(scan_code);
   assign key_acc = key_valid & key_make;

   // Operands are held as BCD digits for display; binary is derived for the ALU.
   always_comb begin
      a_bin = '0;
      b_bin = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         a_bin = W'(a_bin * 10) + W'(a_bcd_q[DW-4-4*i +: 4]);
         b_bin = W'(b_bin * 10) + W'(b_bcd_q[DW-4-4*i +: 4]);
      end
   end

   always_comb begin
      alu_neg = 1'b0;
      case (op_q)
         OP_SUB: begin
            alu_neg = (a_bin < b_bin);
            alu_r   = alu_neg ? RES_W'(b_bin - a_bin) : RES_W'(a_bin - b_bin);
         end
         OP_MUL:  alu_r = RES_W'(a_bin) * RES_W'(b_bin);
         default: alu_r = RES_W'(a_bin) + RES_W'(b_bin);
      endcase
   end

   bin2bcd_seq #(
      .RES_W      (RES_W),
      .RES_DIGITS (RES_DIGITS)
   ) u_bin2bcd (
      .clk_i   (clk_100Hz),
      .rst_i   (rst_p),
      .start_i (conv_start),
      .bin_i   (alu_r),
      .done_o  (conv_done),
      .bcd_o   (conv_bcd)
   );

   always_ff @(posedge clk_100Hz) begin
      if (rst_p) begin
         state_q <= S_A;
         a_bcd_q <= '0;
         b_bcd_q <= '0;
         a_cnt_q <= '0;
         b_cnt_q <= '0;
         op_q    <= OP_ADD;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_bcd_q <= a_bcd_d;
         b_bcd_q <= b_bcd_d;
         a_cnt_q <= a_cnt_d;
         b_cnt_q <= b_cnt_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_bcd_d    = a_bcd_q;
      b_bcd_d    = b_bcd_q;
      a_cnt_d    = a_cnt_q;
      b_cnt_d    = b_cnt_q;
      op_d       = op_q;
      neg_d      = neg_q;
      conv_start = 1'b0;
      do_clear   = 1'b0;

      case (state_q)
         S_A: if (key_acc) begin
            case (key.kind)
               K_DIGIT: if (a_cnt_q < DIG_MAX) begin
                  a_bcd_d = (a_bcd_q << 4) | DW'(key.val);
                  a_cnt_d = a_cnt_q + 3'd1;
               end
               K_BKSP: if (a_cnt_q != '0) begin
                  a_bcd_d = a_bcd_q >> 4;
                  a_cnt_d = a_cnt_q - 3'd1;
               end
               K_OP: begin
                  op_d    = key.val;
                  state_d = S_B;
               end
               K_ESC:   do_clear = 1'b1;
               default: ;
            endcase
         end
         S_B: if (key_acc) begin
            case (key.kind)
               K_DIGIT: if (b_cnt_q < DIG_MAX) begin
                  b_bcd_d = (b_bcd_q << 4) | DW'(key.val);
                  b_cnt_d = b_cnt_q + 3'd1;
               end
               K_BKSP: if (b_cnt_q != '0) begin
                  b_bcd_d = b_bcd_q >> 4;
                  b_cnt_d = b_cnt_q - 3'd1;
               end
               K_OP:    op_d     = key.val;
               K_ENTER: state_d  = S_CALC;
               K_ESC:   do_clear = 1'b1;
               default: ;
            endcase
         end
         S_CALC: begin
            if (key_acc && key.kind == K_ESC) begin
               do_clear = 1'b1;
            end else begin
               neg_d      = alu_neg;
               conv_start = 1'b1;
               state_d    = S_CONV;
            end
         end
         S_CONV: if (conv_done) state_d = S_RES;
         S_RES:  if (key_acc) do_clear = 1'b1;
         default: state_d = S_A;
      endcase

      if (do_clear) begin
         state_d = S_A;
         a_bcd_d = '0;
         b_bcd_d = '0;
         a_cnt_d = '0;
         b_cnt_d = '0;
         op_d    = OP_ADD;
         neg_d   = 1'b0;
      end
   end

   // Leading zeros are blanked by value; the LSD always shows a digit.
   always_comb begin
      case (state_q)
         S_A:     num = NW'(a_bcd_q);
         S_RES:   num = conv_bcd;
         default: num = NW'(b_bcd_q);
      endcase
      disp_code = num;
      seen      = 1'b0;
      for (int unsigned k = 0; k < RES_DIGITS - 1; k++) begin
         if (!seen && num[4*(RES_DIGITS-1-k) +: 4] == 4'd0)
            disp_code[4*(RES_DIGITS-1-k) +: 4] = DIG_BLANK;
         else
            seen = 1'b1;
      end
      if (state_q == S_B || state_q == S_CALC || state_q == S_CONV)
         disp_code[NW-1 -: 4] = op_q;
   end

   assign busy         = (state_q == S_CONV);
   assign result_valid = (state_q == S_RES);
   assign disp_neg     = result_valid & neg_q;

endmodule

// File: tb/tb_kbd_calc_core.sv
// Randomized and directed checks of kbd_calc_core against a decimal-level
// reference model of the calculator.
module tb_kbd_calc_core;

   localparam int DIGITS     = 2;
   localparam int RES_DIGITS = 4;
   localparam int RES_W      = 14;
   localparam int NW         = 4 * RES_DIGITS;

   localparam logic [8:0] K_ENT  = 9'h05A;
   localparam logic [8:0] K_ENT2 = 9'h15A;
   localparam logic [8:0] K_BS   = 9'h066;
   localparam logic [8:0] K_ESC  = 9'h076;
   localparam logic [8:0] K_ADD  = 9'h079;
   localparam logic [8:0] K_SUB  = 9'h07B;
   localparam logic [8:0] K_SUB2 = 9'h04E;
   localparam logic [8:0] K_MUL  = 9'h07C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_p, key_valid, key_make;
   logic [8:0]    scan_code;
   logic [NW-1:0] disp_code;
   logic          disp_neg, busy, result_valid;

   kbd_calc_core #(.DIGITS(DIGITS), .RES_DIGITS(RES_DIGITS)) dut (
      .clk_100Hz    (clk),
      .rst_p        (rst_p),
      .key_valid    (key_valid),
      .key_make     (key_make),
      .scan_code    (scan_code),
      .disp_code    (disp_code),
      .disp_neg     (disp_neg),
      .busy         (busy),
      .result_valid (result_valid)
   );

   logic [8:0] dig_codes [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                                  9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
   logic [8:0] kp_codes  [10] = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
                                  9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};

   int errors = 0;
   int checks = 0;

   // model: mode 0 = entering A, 1 = entering B, 2 = converting, 3 = result
   int m_mode, m_a, m_b, m_acnt, m_bcnt, m_op, m_r;
   bit m_neg;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int digit_of(input logic [8:0] c);
      for (int i = 0; i < 10; i++)
         if (c == dig_codes[i] || c == kp_codes[i]) return i;
      return -1;
   endfunction

   task automatic model_clear();
      m_mode = 0; m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0; m_op = 0; m_r = 0; m_neg = 0;
   endtask

   function automatic logic [NW-1:0] exp_disp();
      logic [NW-1:0] d;
      int v;
      v = (m_mode == 0) ? m_a : (m_mode == 3) ? m_r : m_b;
      for (int i = 0; i < RES_DIGITS; i++) begin
         d[4*i +: 4] = (i == 0 || v != 0) ? 4'(v % 10) : 4'd15;
         v = v / 10;
      end
      if (m_mode == 1 || m_mode == 2) d[NW-1 -: 4] = 4'(10 + m_op);
      return d;
   endfunction

   task automatic model_key(input logic [8:0] c, input bit make);
      int d;
      if (!make) return;
      if (m_mode == 3 || c == K_ESC) begin
         model_clear();
         return;
      end
      d = digit_of(c);
      if (d >= 0) begin
         if (m_mode == 0 && m_acnt < DIGITS) begin m_a = m_a * 10 + d; m_acnt++; end
         if (m_mode == 1 && m_bcnt < DIGITS) begin m_b = m_b * 10 + d; m_bcnt++; end
      end else if (c == K_BS) begin
         if (m_mode == 0 && m_acnt > 0) begin m_a = m_a / 10; m_acnt--; end
         if (m_mode == 1 && m_bcnt > 0) begin m_b = m_b / 10; m_bcnt--; end
      end else if (c == K_ADD || c == K_SUB || c == K_SUB2 || c == K_MUL) begin
         m_op   = (c == K_ADD) ? 0 : (c == K_MUL) ? 2 : 1;
         m_mode = 1;
      end else if ((c == K_ENT || c == K_ENT2) && m_mode == 1) begin
         case (m_op)
            0: begin m_r = m_a + m_b; m_neg = 0; end
            1: begin m_r = (m_a < m_b) ? m_b - m_a : m_a - m_b; m_neg = (m_a < m_b); end
            default: begin m_r = m_a * m_b; m_neg = 0; end
         endcase
         m_mode = 2;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_disp"}, 32'(disp_code), 32'(exp_disp()));
      chk({tag, "_busy"}, 32'(busy), 32'(m_mode == 2));
      chk({tag, "_rv"},   32'(result_valid), 32'(m_mode == 3));
      chk({tag, "_neg"},  32'(disp_neg), 32'(m_mode == 3 && m_neg && m_r != 0));
   endtask

   // Called one edge after Enter was accepted; Esc mid-conversion must be ignored.
   task automatic run_conv();
      chk("calc_disp", 32'(disp_code), 32'(exp_disp()));
      chk("calc_busy", 32'(busy), 32'd0);
      chk("calc_rv",   32'(result_valid), 32'd0);
      for (int k = 1; k <= RES_W + 2; k++) begin
         @(negedge clk);
         if (k == 4) key_valid = 1'b0;
         chk("lat_rv",   32'(result_valid), 32'(k == RES_W + 2));
         chk("lat_busy", 32'(busy), 32'(k <= RES_W + 1));
         if (k <= RES_W + 1) chk("conv_disp", 32'(disp_code), 32'(exp_disp()));
         if (k == 3) begin
            scan_code = K_ESC; key_make = 1'b1; key_valid = 1'b1;
         end
      end
      m_mode = 3;
      check_all("res");
   endtask

   task automatic press(input logic [8:0] c, input bit make);
      @(negedge clk);
      scan_code = c; key_make = make; key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0; key_make = 1'b0;
      model_key(c, make);
      if (m_mode == 2) run_conv();
      else check_all("key");
   endtask

   initial begin
      int r;
      logic [8:0] c;
      rst_p = 1'b1; key_valid = 1'b0; key_make = 1'b0; scan_code = '0;
      model_clear();
      repeat (3) @(negedge clk);
      rst_p = 1'b0;
      check_all("reset");
      chk("reset_const", 32'(disp_code), 32'h0000FFF0);

      press(dig_codes[1], 1); press(dig_codes[2], 1); press(K_ADD, 1);
      press(kp_codes[3], 1); press(dig_codes[4], 1); press(K_ENT, 1);
      chk("tp_add", 32'(disp_code), 32'h0000FF46);
      chk("tp_add_neg", 32'(disp_neg), 32'd0);

      press(dig_codes[0], 1);
      press(dig_codes[3], 1); press(K_SUB2, 1); press(dig_codes[7], 1); press(K_ENT2, 1);
      chk("tp_sub", 32'(disp_code), 32'h0000FFF4);
      chk("tp_sub_neg", 32'(disp_neg), 32'd1);

      press(K_ESC, 1);
      press(dig_codes[5], 1); press(K_SUB, 1); press(kp_codes[5], 1); press(K_ENT, 1);
      chk("tp_zero", 32'(disp_code), 32'h0000FFF0);
      chk("tp_zero_neg", 32'(disp_neg), 32'd0);

      press(K_BS, 1);
      press(dig_codes[9], 1); press(kp_codes[9], 1); press(K_MUL, 1);
      press(dig_codes[9], 1); press(dig_codes[9], 1); press(K_ENT, 1);
      chk("tp_mul", 32'(disp_code), 32'h00009801);

      press(dig_codes[1], 1);
      press(dig_codes[1], 1); press(dig_codes[2], 1); press(dig_codes[3], 1);
      chk("tp_full", 32'(disp_code), 32'h0000FF12);
      press(K_BS, 1);
      chk("tp_bksp", 32'(disp_code), 32'h0000FFF1);

      press(K_ESC, 1);
      press(dig_codes[4], 1); press(K_ADD, 1); press(K_MUL, 1);
      press(dig_codes[6], 1); press(K_ENT, 1);
      chk("tp_oprep", 32'(disp_code), 32'h0000FF24);
      press(dig_codes[7], 1);
      chk("tp_res_key", 32'(disp_code), 32'h0000FFF0);

      press(dig_codes[5], 1); press(K_ADD, 1); press(K_ESC, 1);
      chk("tp_esc", 32'(disp_code), 32'h0000FFF0);
      press(dig_codes[8], 0);
      chk("tp_release", 32'(disp_code), 32'h0000FFF0);

      // reset mid-conversion, with a simultaneous key that must lose
      press(dig_codes[6], 1); press(K_ADD, 1); press(dig_codes[2], 1);
      @(negedge clk);
      scan_code = K_ENT; key_make = 1'b1; key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_p = 1'b1; scan_code = dig_codes[5]; key_valid = 1'b1;
      @(negedge clk);
      rst_p = 1'b0; key_valid = 1'b0; key_make = 1'b0;
      model_clear();
      check_all("rst_conv");
      press(dig_codes[1], 1); press(K_ADD, 1); press(dig_codes[1], 1); press(K_ENT, 1);

      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 45)
            c = ($urandom_range(0, 1) == 0) ? dig_codes[$urandom_range(0, 9)]
                                            : kp_codes[$urandom_range(0, 9)];
         else if (r < 56) begin
            case ($urandom_range(0, 3))
               0: c = K_ADD;
               1: c = K_SUB;
               2: c = K_SUB2;
               default: c = K_MUL;
            endcase
         end
         else if (r < 64) c = ($urandom_range(0, 1) == 0) ? K_ENT : K_ENT2;
         else if (r < 72) c = K_BS;
         else if (r < 75) c = K_ESC;
         else if (r < 87) c = 9'($urandom_range(0, 511));
         else c = dig_codes[$urandom_range(0, 9)];
         press(c, (r < 87) ? 1'b1 : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
